// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd
//   Sequential binary-to-BCD converter using shift-add-3 (double dabble),
//   one bit per clock. It sits between the calculator core and the display
//   logic. The published Bcd/Neg pair is only rewritten on Done, so the
//   display never sees a partially converted value.
//
// Ports
//   Clk         : system clock, rising-edge active
//   Reset       : synchronous, active-high reset
//   Start       : one-cycle convert request, honoured when Busy=0
//   Signed_mode : sampled with Start; 1 treats Bin as two's complement
//   Bin         : value to convert, sampled on the accepting edge
//   Busy        : conversion in progress
//   Done        : one-cycle pulse; Bcd/Neg change in the same cycle
//   Neg         : last result was negative (signed mode only)
//   Bcd         : packed BCD digits, [3:0] is the units digit
module calc_bin2bcd #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  Signed_mode,
   input  logic [WIDTH-1:0]      Bin,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Neg,
   output logic [4*DIGITS-1:0]   Bcd
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {
      QI    = 2'd0,
      QCONV = 2'd1,
      QDONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BCD_W-1:0]    work_bcd_q, work_bcd_d;
   logic [WIDTH-1:0]    work_bin_q, work_bin_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                work_neg_q, work_neg_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic                neg_q, neg_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                accept;
   logic                take_neg;
   logic signed [WIDTH-1:0] bin_s;
   logic signed [WIDTH-1:0] mag_s;
   logic [BCD_W+WIDTH-1:0]  shifted;

   // Nibble correction: any digit >= 5 gets +3 so that the following
   // left shift carries correctly into the next decimal digit.
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Two's-complement magnitude; the most negative value maps onto itself,
   // which read as unsigned is exactly its magnitude (0x8000 -> 32768).
   function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
      return -v;
   endfunction

   always_comb begin
      state_d    = state_q;
      work_bcd_d = work_bcd_q;
      work_bin_d = work_bin_q;
      cnt_d      = cnt_q;
      work_neg_d = work_neg_q;
      bcd_d      = bcd_q;
      neg_d      = neg_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      accept   = Start && (state_q != QCONV);
      take_neg = Signed_mode && Bin[WIDTH-1];
      bin_s    = Bin;
      mag_s    = negate(bin_s);
      shifted  = {add3_digits(work_bcd_q), work_bin_q} << 1;

      case (state_q)
         QI, QDONE: begin
            if (accept) begin
               work_bcd_d = '0;
               work_bin_d = take_neg ? mag_s : Bin;
               work_neg_d = take_neg;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = QCONV;
            end else begin
               busy_d     = 1'b0;
               state_d    = QI;
            end
         end
         QCONV: begin
            {work_bcd_d, work_bin_d} = shifted;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               // Last iteration: publish the freshly shifted digits directly.
               bcd_d   = shifted[BCD_W+WIDTH-1:WIDTH];
               neg_d   = work_neg_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = QDONE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = QI;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= QI;
         work_bcd_q <= '0;
         work_bin_q <= '0;
         cnt_q      <= '0;
         work_neg_q <= 1'b0;
         bcd_q      <= '0;
         neg_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         work_bcd_q <= work_bcd_d;
         work_bin_q <= work_bin_d;
         cnt_q      <= cnt_d;
         work_neg_q <= work_neg_d;
         bcd_q      <= bcd_d;
         neg_q      <= neg_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign Neg  = neg_q;
   assign Bcd  = bcd_q;

endmodule

// File: tb/tb_calc_bin2bcd.sv
// Scoreboard bench for calc_bin2bcd: stimulus pushes expected results,
// a monitor pops and compares on every Done pulse.
module tb_calc_bin2bcd;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic        Signed_mode;
   logic [15:0] Bin;
   logic        Busy;
   logic        Done;
   logic        Neg;
   logic [19:0] Bcd;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic done_prev = 1'b0;

   typedef struct {
      logic [19:0] bcd;
      logic        neg;
      int          at_cyc;
   } exp_t;

   exp_t sb_q[$];

   calc_bin2bcd #(.WIDTH(16), .DIGITS(5)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Signed_mode(Signed_mode),
      .Bin(Bin), .Busy(Busy), .Done(Done), .Neg(Neg), .Bcd(Bcd)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor
   always @(negedge Clk) begin
      exp_t e;
      if (Done) begin
         chk("done_busy_exclusive", {31'd0, Busy}, 32'd0);
         chk("done_single_cycle", {31'd0, done_prev}, 32'd0);
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done got Bcd=%h Neg=%b expected no Done", Bcd, Neg);
         end else begin
            e = sb_q.pop_front();
            chk("bcd", {12'd0, Bcd}, {12'd0, e.bcd});
            chk("neg", {31'd0, Neg}, {31'd0, e.neg});
            chk("latency", cyc, e.at_cyc);
         end
      end
      done_prev = Done;
   end

   // Called at a negedge: Start is seen at the next edge (E0); Done becomes
   // visible at the negedge following E16, i.e. 17 cycle-counts later.
   task automatic start_now(input logic [15:0] b, input logic sm,
                            input logic [19:0] eb, input logic en);
      exp_t e;
      Start = 1'b1; Bin = b; Signed_mode = sm;
      e.bcd = eb; e.neg = en; e.at_cyc = cyc + 17;
      sb_q.push_back(e);
      @(negedge Clk);
      Start = 1'b0;
   endtask

   task automatic start_conv(input logic [15:0] b, input logic sm,
                             input logic [19:0] eb, input logic en);
      @(negedge Clk);
      start_now(b, sm, eb, en);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb_q.size() != 0 || Busy || Done) && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL wait_idle timeout got pending=%0d expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      int n;
      Reset = 1'b1; Start = 1'b1; Signed_mode = 1'b0; Bin = 16'hFFFF;

      // Reset overrides Start
      repeat (2) @(negedge Clk);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_neg",  {31'd0, Neg},  32'd0);
      chk("rst_bcd",  {12'd0, Bcd},  32'd0);
      Reset = 1'b0; Start = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_no_start", {31'd0, Busy}, 32'd0);

      // Unsigned / signed vectors
      start_conv(16'hFFFF, 1'b0, 20'h65535, 1'b0); wait_idle();
      start_conv(16'h0000, 1'b0, 20'h00000, 1'b0); wait_idle();
      start_conv(16'hFFFF, 1'b1, 20'h00001, 1'b1); wait_idle();
      start_conv(16'h8000, 1'b1, 20'h32768, 1'b1); wait_idle();
      start_conv(16'h8000, 1'b0, 20'h32768, 1'b0); wait_idle();
      start_conv(16'h0000, 1'b1, 20'h00000, 1'b0); wait_idle();
      start_conv(16'h7FFF, 1'b1, 20'h32767, 1'b0); wait_idle();

      // Busy rejection, prior result held until Done
      start_conv(16'd1234, 1'b0, 20'h01234, 1'b0);
      repeat (4) begin
         chk("hold_bcd", {12'd0, Bcd}, 32'h32767);
         @(negedge Clk);
      end
      Start = 1'b1; Bin = 16'd9999; Signed_mode = 1'b0;
      @(negedge Clk);
      Start = 1'b0;
      n = 0;
      while (!Done && n < 40) begin
         chk("hold_bcd", {12'd0, Bcd}, 32'h32767);
         chk("busy_during_conv", {31'd0, Busy}, 32'd1);
         @(negedge Clk);
         n++;
      end
      wait_idle();
      repeat (20) @(negedge Clk);

      // Back-to-back: start the next conversion during the Done cycle
      start_conv(16'd100, 1'b0, 20'h00100, 1'b0);
      n = 0;
      while (!Done && n < 40) begin
         @(negedge Clk);
         n++;
      end
      chk("b2b_done_seen", {31'd0, Done}, 32'd1);
      start_now(16'd42, 1'b0, 20'h00042, 1'b0);
      wait_idle();

      // Reset mid-conversion
      start_conv(16'd5000, 1'b0, 20'h05000, 1'b0);
      repeat (8) @(negedge Clk);
      Reset = 1'b1;
      sb_q.delete();
      @(negedge Clk);
      Reset = 1'b0;
      chk("midrst_busy", {31'd0, Busy}, 32'd0);
      chk("midrst_bcd",  {12'd0, Bcd},  32'd0);
      chk("midrst_neg",  {31'd0, Neg},  32'd0);
      repeat (20) @(negedge Clk);
      chk("midrst_bcd_after", {12'd0, Bcd}, 32'd0);
      start_conv(16'd5000, 1'b0, 20'h05000, 1'b0); wait_idle();

      repeat (5) @(negedge Clk);
      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
